id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the five-stage ARM core. It captures the decoded instruction, its control word, the register-file read values and the status flags at the end of ID, and presents them to EX for one instruction per cycle. EX feeds `val_rm`, `imm` and `shift_operand` to the Val2 generator and the ALU; the memory enables drive the generator's load/store path. Stall (freeze), branch flush and bubble injection all happen here, and a `valid_out` bit tags every slot.

## Interface
- No parameters; all widths are fixed by the ISA subset.
- `clk  in  1`  core clock, rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `freeze  in  1`  hold all outputs (memory stall).
- `flush  in  1`  replace the incoming slot with a bubble (branch taken in EX).
- `valid_in  in  1`  ID slot holds a real instruction.
- `wb_en_in, mem_R_en_in, mem_W_en_in, B_in, S_in  in  1 each`  control bits.
- `exe_cmd_in  in  4`  ALU command.
- `pc_in  in  32`  PC+4 of the instruction.
- `val_rn_in, val_rm_in  in  32 each`  register-file read data.
- `imm_in  in  1`  immediate-operand bit (I).
- `shift_operand_in  in  12`  instruction bits [11:0].
- `signed_imm_24_in  in  24`  branch offset.
- `dest_in, src1_in, src2_in  in  4 each`  register numbers (forwarding/hazard).
- `status_in  in  4`  NZCV from the status register.
- `*_out`  out  same widths as `*_in`  registered copies. `valid_out` is 1 bit.

## Operation
- Priority per rising edge: `rst` > `freeze` > `flush` > normal load.
- `rst`: every output is 0, including `valid_out`, `pc_out` and the data fields.
- `freeze`: every output holds its value. `flush` is ignored while frozen. The branch stays in EX, so `flush` is still asserted when the freeze ends and takes effect then.
- `flush` (not frozen): this is a bubble.
  - `valid_out`, `wb_en_out`, `mem_R_en_out`, `mem_W_en_out`, `B_out` and `S_out` become 0. `exe_cmd_out` becomes 0.
  - Data fields (`pc`, `val_rn`, `val_rm`, `imm`, `shift_operand`, `signed_imm_24`, `dest`, `src1`, `src2`, `status`) become 0.
- Normal load: every `*_out` takes its `*_in`.
- Gating on `valid_in`: if `valid_in`=0 on a load, the control bits and `valid_out` are forced to 0. The data fields still load, which keeps the hazard unit's `src` compares deterministic.
- Invariant: when `valid_out`=0, `wb_en_out`, `mem_R_en_out`, `mem_W_en_out`, `B_out` and `S_out` are all 0.
- No arithmetic in the block. Widths pass through unchanged and there is no sign extension.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs.
- Throughput is one slot per cycle while `freeze`=0.
- Outputs change only on a rising `clk` edge. There are no combinational paths from inputs to outputs.
- Reset mid-stream: `rst` asserted in any cycle wins over a simultaneous `freeze` or `flush`. Outputs are 0 after that edge.
- `freeze` and `flush` high together: hold. The first edge with `freeze`=0 and `flush`=1 loads a bubble.
- Releasing `freeze` with `flush`=0 loads the current ID slot on the next edge. No slot is duplicated or dropped.

## Structure
- The shared package `arm_pkg` holds:
  - the `exe_cmd` encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR, NOP=0);
  - the bubble value of the control word;
  - width constants (`REG_ADDR_W`=4, `SHIFT_OP_W`=12, `BR_OFF_W`=24).
- Control fields are grouped in a packed `ctrl_t` struct (`wb_en`, `mem_R_en`, `mem_W_en`, `B`, `S`, `exe_cmd`) defined in `arm_pkg`. Flushing is then a single assignment of the bubble constant.
- One natural sub-module, `pipe_field_reg`: a width-parameterised register with sync reset, hold and clear. It is instantiated once for the control struct and once for the concatenated data fields.

## Test plan
- Reset: drive nonzero inputs and `rst`=1 for 2 cycles. All outputs are 0. `valid_out`=0.
- Pass-through: `valid_in`=1, `pc_in`=0x10, `val_rm_in`=0xFF, `imm_in`=1, `shift_operand_in`=0x2AB, `mem_R_en_in`=1, `exe_cmd_in`=LDR. One cycle later the outputs match exactly.
- Freeze:
  - Load slot A.
  - Hold `freeze`=1 for 3 cycles while the inputs change to B. The outputs stay A.
  - Release `freeze`. B appears on the next edge.
- Flush: with `wb_en_in`=1, `dest_in`=5, `val_rn_in`=0x1234, assert `flush`. The next edge gives `valid_out`=0, `wb_en_out`=0, `dest_out`=0, `val_rn_out`=0.
- Freeze with flush:
  - Assert both for 2 cycles. The outputs hold.
  - Drop `freeze`. A bubble is loaded.
  - Drop `flush`. The following edge loads normally.
- Invalid slot: `valid_in`=0, `mem_W_en_in`=1, `src1_in`=3. The next edge gives `mem_W_en_out`=0, `valid_out`=0, `src1_out`=3.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the five-stage ARM core pipeline.
//   - exe_cmd encodings for the ALU (NOP is 0, the bubble command)
//   - ctrl_t: packed control word carried from ID to EX
//   - CTRL_BUBBLE: control word of an empty slot
//   - width constants for register numbers, shifter operand, branch offset
package arm_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int BR_OFF_W   = 24;
    localparam int EXE_CMD_W  = 4;

    // Several mnemonics share an ALU command (CMP computes SUB, TST computes
    // AND, LDR/STR compute an ADD address), so these are plain constants
    // rather than enum members.
    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_R_en;
        logic                 mem_W_en;
        logic                 B;
        logic                 S;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{wb_en: 1'b0, mem_R_en: 1'b0, mem_W_en: 1'b0,
                                      B: 1'b0, S: 1'b0, exe_cmd: EXE_NOP};

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: width-parameterised pipeline register.
// Priority on each rising edge: rst (clear) > hold (keep) > clear (zero) > load d.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   hold      - keep current contents
//   clear     - load zero instead of d
//   d / q     - WIDTH-bit data in / registered data out
module pipe_field_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            q <= clear ? '0 : d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the five-stage ARM core.
// Captures the decoded control word, register-file read data, immediate and
// shifter fields, register numbers and NZCV at the end of ID and presents
// them to EX one cycle later. Handles stall (freeze), branch flush (bubble)
// and tags each slot with valid_out.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   freeze               - hold every output (memory stall), beats flush
//   flush                - load a bubble (branch taken in EX)
//   valid_in             - ID slot holds a real instruction
//   *_in                 - ID-stage fields
//   *_out                - registered copies for EX, valid_out tags the slot
module id_ex_reg
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_R_en_in,
    input  logic                  mem_W_en_in,
    input  logic                  B_in,
    input  logic                  S_in,
    input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           val_rn_in,
    input  logic [31:0]           val_rm_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [BR_OFF_W-1:0]   signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [3:0]            status_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_R_en_out,
    output logic                  mem_W_en_out,
    output logic                  B_out,
    output logic                  S_out,
    output logic [EXE_CMD_W-1:0]  exe_cmd_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           val_rn_out,
    output logic [31:0]           val_rm_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [BR_OFF_W-1:0]   signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [3:0]            status_out
);

    localparam int CTRL_W = $bits(ctrl_t) + 1;
    localparam int DATA_W = 32 + 32 + 32 + 1 + SHIFT_OP_W + BR_OFF_W
                          + 3 * REG_ADDR_W + 4;

    ctrl_t             ctrl_in;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;
    logic [CTRL_W-1:0] ctrl_vec_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        ctrl_in.wb_en    = wb_en_in;
        ctrl_in.mem_R_en = mem_R_en_in;
        ctrl_in.mem_W_en = mem_W_en_in;
        ctrl_in.B        = B_in;
        ctrl_in.S        = S_in;
        ctrl_in.exe_cmd  = exe_cmd_in;
        // An invalid ID slot must never enable writeback, memory or branch in
        // EX, so its control word is replaced by the bubble. Data still loads
        // so the hazard unit compares against defined register numbers.
        ctrl_d = valid_in ? ctrl_in : CTRL_BUBBLE;
    end

    assign data_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                     signed_imm_24_in, dest_in, src1_in, src2_in, status_in};

    // valid rides in the control register so that flush and reset clear it
    // together with the enables, keeping the invalid-implies-no-enables rule.
    pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (flush),
        .d     ({valid_in, ctrl_d}),
        .q     (ctrl_vec_q)
    );

    pipe_field_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (flush),
        .d     (data_d),
        .q     (data_q)
    );

    assign valid_out = ctrl_vec_q[CTRL_W-1];
    assign ctrl_q    = ctrl_vec_q[CTRL_W-2:0];

    assign wb_en_out    = ctrl_q.wb_en;
    assign mem_R_en_out = ctrl_q.mem_R_en;
    assign mem_W_en_out = ctrl_q.mem_W_en;
    assign B_out        = ctrl_q.B;
    assign S_out        = ctrl_q.S;
    assign exe_cmd_out  = ctrl_q.exe_cmd;

    assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            signed_imm_24_out, dest_out, src1_out, src2_out, status_out} = data_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in;
    logic        wb_en_in, mem_R_en_in, mem_W_en_in, B_in, S_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in, status_in;

    logic        valid_out, wb_en_out, mem_R_en_out, mem_W_en_out, B_out, S_out;
    logic [3:0]  exe_cmd_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out, status_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .wb_en_in(wb_en_in), .mem_R_en_in(mem_R_en_in), .mem_W_en_in(mem_W_en_in),
        .B_in(B_in), .S_in(S_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_R_en_out(mem_R_en_out),
        .mem_W_en_out(mem_W_en_out), .B_out(B_out), .S_out(S_out),
        .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .status_out(status_out)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected EX-side slot, derived from the stated rules.
    typedef struct {
        logic        valid, wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] off;
        logic [3:0]  dest, src1, src2, status;
    } slot_t;

    slot_t m;
    bit    m_ok = 0;

    function automatic slot_t zero_slot();
        slot_t z;
        z.valid = 0; z.wb = 0; z.mr = 0; z.mw = 0; z.b = 0; z.s = 0; z.cmd = 0;
        z.pc = 0; z.rn = 0; z.rm = 0; z.imm = 0; z.sh = 0; z.off = 0;
        z.dest = 0; z.src1 = 0; z.src2 = 0; z.status = 0;
        return z;
    endfunction

    always begin
        @(posedge clk);
        if (rst) begin
            m = zero_slot();
            m_ok = 1;
        end else if (!freeze) begin
            if (flush) begin
                m = zero_slot();
            end else begin
                m.pc = pc_in; m.rn = val_rn_in; m.rm = val_rm_in; m.imm = imm_in;
                m.sh = shift_operand_in; m.off = signed_imm_24_in; m.dest = dest_in;
                m.src1 = src1_in; m.src2 = src2_in; m.status = status_in;
                m.valid = valid_in;
                m.wb  = valid_in & wb_en_in;
                m.mr  = valid_in & mem_R_en_in;
                m.mw  = valid_in & mem_W_en_in;
                m.b   = valid_in & B_in;
                m.s   = valid_in & S_in;
                m.cmd = valid_in ? exe_cmd_in : 4'd0;
            end
        end
        #1;
        if (m_ok) begin
            cmp("m_valid", {31'd0, valid_out}, {31'd0, m.valid});
            cmp("m_ctrl", {26'd0, wb_en_out, mem_R_en_out, mem_W_en_out, B_out, S_out, exe_cmd_out},
                {26'd0, m.wb, m.mr, m.mw, m.b, m.s, m.cmd});
            cmp("m_pc", pc_out, m.pc);
            cmp("m_rn", val_rn_out, m.rn);
            cmp("m_rm", val_rm_out, m.rm);
            cmp("m_imm_sh", {19'd0, imm_out, shift_operand_out}, {19'd0, m.imm, m.sh});
            cmp("m_off", {8'd0, signed_imm_24_out}, {8'd0, m.off});
            cmp("m_regs", {16'd0, dest_out, src1_out, src2_out, status_out},
                {16'd0, m.dest, m.src1, m.src2, m.status});
            if (!valid_out)
                cmp("m_invariant", {27'd0, wb_en_out, mem_R_en_out, mem_W_en_out, B_out, S_out}, 32'd0);
        end
    end

    // Sample point is posedge+2, after the model compare at posedge+1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        valid_in = 0; wb_en_in = 0; mem_R_en_in = 0; mem_W_en_in = 0; B_in = 0; S_in = 0;
        exe_cmd_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0;
        shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0; src1_in = 0;
        src2_in = 0; status_in = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with nonzero inputs
        rst = 1; freeze = 0; flush = 0;
        valid_in = 1; wb_en_in = 1; mem_R_en_in = 1; mem_W_en_in = 1; B_in = 1; S_in = 1;
        exe_cmd_in = 4'hF; pc_in = 32'hDEADBEEF; val_rn_in = 32'h1; val_rm_in = 32'h2;
        imm_in = 1; shift_operand_in = 12'hFFF; signed_imm_24_in = 24'hABCDEF;
        dest_in = 4'hF; src1_in = 4'hE; src2_in = 4'hD; status_in = 4'hC;
        tick(); tick();
        cmp("rst_valid", {31'd0, valid_out}, 32'd0);
        cmp("rst_pc", pc_out, 32'd0);
        cmp("rst_rm", val_rm_out, 32'd0);
        cmp("rst_cmd", {28'd0, exe_cmd_out}, 32'd0);

        // Pass-through of an LDR slot
        rst = 0; clear_inputs();
        valid_in = 1; pc_in = 32'h10; val_rm_in = 32'hFF; imm_in = 1;
        shift_operand_in = 12'h2AB; mem_R_en_in = 1; exe_cmd_in = 4'b0010;
        tick();
        cmp("pt_pc", pc_out, 32'h10);
        cmp("pt_rm", val_rm_out, 32'hFF);
        cmp("pt_imm", {31'd0, imm_out}, 32'd1);
        cmp("pt_sh", {20'd0, shift_operand_out}, 32'h2AB);
        cmp("pt_mr", {31'd0, mem_R_en_out}, 32'd1);
        cmp("pt_cmd", {28'd0, exe_cmd_out}, 32'd2);
        cmp("pt_valid", {31'd0, valid_out}, 32'd1);

        // Freeze holds slot A while inputs move to B
        clear_inputs(); valid_in = 1; pc_in = 32'hA0; dest_in = 4'd1; wb_en_in = 1;
        tick();
        pc_in = 32'hB0; dest_in = 4'd2; freeze = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("frz_pc", pc_out, 32'hA0);
            cmp("frz_dest", {28'd0, dest_out}, 32'd1);
        end
        freeze = 0;
        tick();
        cmp("unfrz_pc", pc_out, 32'hB0);
        cmp("unfrz_dest", {28'd0, dest_out}, 32'd2);

        // Flush loads a bubble
        wb_en_in = 1; dest_in = 4'd5; val_rn_in = 32'h1234; flush = 1;
        tick();
        cmp("fl_valid", {31'd0, valid_out}, 32'd0);
        cmp("fl_wb", {31'd0, wb_en_out}, 32'd0);
        cmp("fl_dest", {28'd0, dest_out}, 32'd0);
        cmp("fl_rn", val_rn_out, 32'd0);

        // Freeze together with flush
        flush = 0; clear_inputs(); valid_in = 1; pc_in = 32'hC0; S_in = 1;
        tick();
        freeze = 1; flush = 1; pc_in = 32'hD0;
        tick(); tick();
        cmp("ff_hold_pc", pc_out, 32'hC0);
        cmp("ff_hold_valid", {31'd0, valid_out}, 32'd1);
        freeze = 0;
        tick();
        cmp("ff_bubble_valid", {31'd0, valid_out}, 32'd0);
        cmp("ff_bubble_pc", pc_out, 32'd0);
        flush = 0;
        tick();
        cmp("ff_load_pc", pc_out, 32'hD0);
        cmp("ff_load_valid", {31'd0, valid_out}, 32'd1);

        // Invalid slot: control gated, data still loads
        clear_inputs(); valid_in = 0; mem_W_en_in = 1; src1_in = 4'd3;
        tick();
        cmp("inv_mw", {31'd0, mem_W_en_out}, 32'd0);
        cmp("inv_valid", {31'd0, valid_out}, 32'd0);
        cmp("inv_src1", {28'd0, src1_out}, 32'd3);

        // Directed mixed patterns, checked by the model
        for (int i = 0; i < 24; i++) begin
            valid_in = i[0] | i[2]; wb_en_in = i[1]; mem_R_en_in = i[2]; mem_W_en_in = i[3];
            B_in = ~i[0]; S_in = i[4]; exe_cmd_in = 4'(i * 3);
            pc_in = 32'h1000 + 32'(i * 4); val_rn_in = 32'(i) * 32'h01010101;
            val_rm_in = ~val_rn_in; imm_in = i[1]; shift_operand_in = 12'(i * 37);
            signed_imm_24_in = 24'hFFFFF0 - 24'(i); dest_in = 4'(i); src1_in = 4'(i + 1);
            src2_in = 4'(i + 2); status_in = 4'(15 - i);
            freeze = (i % 5 == 3); flush = (i % 7 == 4);
            tick();
        end

        // Reset wins over freeze and flush
        clear_inputs(); valid_in = 1; pc_in = 32'h44; tick();
        rst = 1; freeze = 1; flush = 1; pc_in = 32'h55;
        tick();
        cmp("rst_mid_pc", pc_out, 32'd0);
        cmp("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        rst = 0; freeze = 0; flush = 0;
        tick();
        cmp("post_rst_pc", pc_out, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
